wd_bus_unlock: RTL and testbench

Bus front-end for the watchdog: snoops the shared ABUS/DBUS, detects the two-byte unlock key (0xAA then 0x55), and opens a fixed four-cycle write window. During the window it updates the watchdog configuration registers and emits control strobes. It sits directly upstream of the watchdog core, which consumes FWLEN/SWLEN/RSTLIM and the INIT/SVC pulses.

---
 rtl/wd_pkg.sv | 25 ++
 rtl/wd_key_detect.sv | 86 ++++++++
 rtl/wd_bus_unlock.sv | 125 ++++++++++++
 tb/tb_wd_bus_unlock.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// Shared constants and FSM state type for the watchdog bus unlock front-end.
// WD_CFG_LOCK_EN (used by wd_bus_unlock) enables the CTRL bit 7 configuration lock.
package wd_pkg;

    localparam logic [7:0] KEY_A = 8'hAA;
    localparam logic [7:0] KEY_B = 8'h55;

    localparam logic [1:0] ADDR_FW   = 2'b00;
    localparam logic [1:0] ADDR_SW   = 2'b01;
    localparam logic [1:0] ADDR_CTRL = 2'b10;
    localparam logic [1:0] ADDR_RL   = 2'b11;

    localparam int INIT_BIT = 3;
    localparam int SVC_BIT  = 0;
    localparam int LOCK_BIT = 7;

    localparam int WIN_LEN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY1 = 2'd1,
        WIN  = 2'd2
    } wd_state_e;

endpackage

// File: rtl/wd_key_detect.sv
// Unlock key detector: tracks the 0xAA/0x55 sequence on the snooped bus and
// times the fixed-length write window. WD_CFG_LOCK_EN has no effect here.
module wd_key_detect
    import wd_pkg::*;
#(
    parameter int unsigned KEY_TMO = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] abus,
    input  logic [7:0] dbus,
    output logic       win_open,
    output logic       key_err
);

    // The key bytes are only recognised on address 00.
    localparam logic [1:0] KEY_ADDR  = 2'b00;
    localparam logic [7:0] HOLD_LAST = 8'(KEY_TMO - 1);
    localparam logic [1:0] WIN_LAST  = 2'(WIN_LEN - 1);

    wd_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic       key_err_q, key_err_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wcnt_d    = wcnt_q;
        key_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (abus == KEY_ADDR && dbus == KEY_A) begin
                    state_d = KEY1;
                    hold_d  = '0;
                end
            end
            KEY1: begin
                if (abus != KEY_ADDR) begin
                    state_d   = IDLE;
                    key_err_d = 1'b1;
                end else if (dbus == KEY_A) begin
                    // hold_q counts repeats after the first 0xAA, so KEY_TMO bytes are tolerated
                    if (hold_q == HOLD_LAST) begin
                        state_d   = IDLE;
                        key_err_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end else if (dbus == KEY_B) begin
                    state_d = WIN;
                    wcnt_d  = '0;
                end else begin
                    state_d   = IDLE;
                    key_err_d = 1'b1;
                end
            end
            WIN: begin
                if (wcnt_q == WIN_LAST) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            wcnt_q    <= '0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wcnt_q    <= wcnt_d;
            key_err_q <= key_err_d;
        end
    end

    assign win_open = (state_q == WIN);
    assign key_err  = key_err_q;

endmodule

// File: rtl/wd_bus_unlock.sv
// Watchdog bus front-end: configuration registers and control strobes written
// during the unlocked window. Define WD_CFG_LOCK_EN to enable the CTRL bit 7 lock.
module wd_bus_unlock
    import wd_pkg::*;
#(
    parameter logic [7:0]  FW_RST  = 8'hFF,
    parameter logic [7:0]  SW_RST  = 8'h0F,
    parameter logic [7:0]  RL_RST  = 8'h04,
    parameter int unsigned KEY_TMO = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] ABUS,
    input  logic [7:0] DBUS,
    output logic [7:0] FWLEN,
    output logic [7:0] SWLEN,
    output logic [7:0] RSTLIM,
    output logic       INIT,
    output logic       SVC,
    output logic       WINOPEN,
    output logic       KEYERR,
    output logic       CFGERR,
    output logic       CFGLOCK
);

    logic       win_open;
    logic       locked;
    logic [7:0] fwlen_q, fwlen_d;
    logic [7:0] swlen_q, swlen_d;
    logic [7:0] rstlim_q, rstlim_d;
    logic       init_q, init_d;
    logic       svc_q, svc_d;
    logic       cfgerr_q, cfgerr_d;

    wd_key_detect #(.KEY_TMO(KEY_TMO)) u_key_detect (
        .clk      (CLK),
        .rst_n    (RST),
        .abus     (ABUS),
        .dbus     (DBUS),
        .win_open (win_open),
        .key_err  (KEYERR)
    );

`ifdef WD_CFG_LOCK_EN
    logic lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (win_open && ABUS == ADDR_CTRL && DBUS[LOCK_BIT]) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        fwlen_d  = fwlen_q;
        swlen_d  = swlen_q;
        rstlim_d = rstlim_q;
        init_d   = 1'b0;
        svc_d    = 1'b0;
        cfgerr_d = 1'b0;
        if (win_open) begin
            if (ABUS == ADDR_CTRL) begin
                init_d = DBUS[INIT_BIT];
                svc_d  = DBUS[SVC_BIT];
            end else if (!locked) begin
                // A zero length would stall the watchdog core, so it is refused
                if (DBUS == 8'h00) begin
                    cfgerr_d = 1'b1;
                end else begin
                    unique case (ABUS)
                        ADDR_FW: fwlen_d  = DBUS;
                        ADDR_SW: swlen_d  = DBUS;
                        ADDR_RL: rstlim_d = DBUS;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fwlen_q  <= FW_RST;
            swlen_q  <= SW_RST;
            rstlim_q <= RL_RST;
            init_q   <= 1'b0;
            svc_q    <= 1'b0;
            cfgerr_q <= 1'b0;
        end else begin
            fwlen_q  <= fwlen_d;
            swlen_q  <= swlen_d;
            rstlim_q <= rstlim_d;
            init_q   <= init_d;
            svc_q    <= svc_d;
            cfgerr_q <= cfgerr_d;
        end
    end

    assign FWLEN   = fwlen_q;
    assign SWLEN   = swlen_q;
    assign RSTLIM  = rstlim_q;
    assign INIT    = init_q;
    assign SVC     = svc_q;
    assign CFGERR  = cfgerr_q;
    assign WINOPEN = win_open;
`ifdef WD_CFG_LOCK_EN
    assign CFGLOCK = lock_q;
`else
    assign CFGLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_wd_bus_unlock.sv
// Self-checking bench for wd_bus_unlock against a cycle-level behavioural model.
// Follows WD_CFG_LOCK_EN so the same bench covers both builds.
module tb_wd_bus_unlock;

    localparam int KTMO = 8;
`ifdef WD_CFG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] ABUS;
    logic [7:0] DBUS;
    logic [7:0] FWLEN, SWLEN, RSTLIM;
    logic       INIT, SVC, WINOPEN, KEYERR, CFGERR, CFGLOCK;

    wd_bus_unlock #(
        .FW_RST (8'hFF),
        .SW_RST (8'h0F),
        .RL_RST (8'h04),
        .KEY_TMO(KTMO)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ABUS   (ABUS),
        .DBUS   (DBUS),
        .FWLEN  (FWLEN),
        .SWLEN  (SWLEN),
        .RSTLIM (RSTLIM),
        .INIT   (INIT),
        .SVC    (SVC),
        .WINOPEN(WINOPEN),
        .KEYERR (KEYERR),
        .CFGERR (CFGERR),
        .CFGLOCK(CFGLOCK)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Behavioural model: window = number of write cycles still owed,
    // aa_run = consecutive 0xAA bytes seen while a key is pending (0 = none).
    logic [7:0] m_fw, m_sw, m_rl;
    logic       m_init, m_svc, m_keyerr, m_cfgerr, m_lock;
    int         m_win, m_aa;

    function automatic logic [29:0] obs_vec();
        return {FWLEN, SWLEN, RSTLIM, INIT, SVC, WINOPEN, KEYERR, CFGERR, CFGLOCK};
    endfunction

    function automatic logic [29:0] exp_vec();
        return {m_fw, m_sw, m_rl, m_init, m_svc, (m_win > 0), m_keyerr, m_cfgerr, m_lock};
    endfunction

    task automatic model_reset();
        m_fw = 8'hFF; m_sw = 8'h0F; m_rl = 8'h04;
        m_init = 0; m_svc = 0; m_keyerr = 0; m_cfgerr = 0; m_lock = 0;
        m_win = 0; m_aa = 0;
    endtask

    task automatic model_step(input logic [1:0] a, input logic [7:0] d);
        m_init = 0; m_svc = 0; m_keyerr = 0; m_cfgerr = 0;
        if (m_win > 0) begin
            if (a == 2'b10) begin
                m_init = d[3];
                m_svc  = d[0];
                if (LOCK_EN && d[7]) m_lock = 1;
            end else if (!m_lock) begin
                if (d == 8'h00) m_cfgerr = 1;
                else if (a == 2'b00) m_fw = d;
                else if (a == 2'b01) m_sw = d;
                else m_rl = d;
            end
            m_win = m_win - 1;
        end else if (m_aa > 0) begin
            if (a == 2'b00 && d == 8'hAA) begin
                m_aa = m_aa + 1;
                if (m_aa > KTMO) begin m_keyerr = 1; m_aa = 0; end
            end else if (a == 2'b00 && d == 8'h55) begin
                m_aa = 0; m_win = 4;
            end else begin
                m_keyerr = 1; m_aa = 0;
            end
        end else if (a == 2'b00 && d == 8'hAA) begin
            m_aa = 1;
        end
    endtask

    task automatic cyc(input logic [1:0] a, input logic [7:0] d);
        @(negedge CLK);
        ABUS = a;
        DBUS = d;
        @(posedge CLK);
        model_step(a, d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; ABUS = 2'b00; DBUS = 8'h00;
        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (FWLEN !== 8'hFF) begin bad++; $display("FAIL reset_fwlen got=%h exp=ff", FWLEN); end
        total++;
        if (SWLEN !== 8'h0F) begin bad++; $display("FAIL reset_swlen got=%h exp=0f", SWLEN); end
        total++;
        if (RSTLIM !== 8'h04) begin bad++; $display("FAIL reset_rstlim got=%h exp=04", RSTLIM); end
        total++;
        if ({INIT, SVC, WINOPEN, KEYERR, CFGERR, CFGLOCK} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes got=%b exp=000000", {INIT, SVC, WINOPEN, KEYERR, CFGERR, CFGLOCK});
        end
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_idle i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
    endtask

    task automatic test_program();
        logic [9:0] q[$];
        int wo;
        q = '{{2'b00, 8'h36}, {2'b00, 8'h11}, {2'b00, 8'hAA}, {2'b00, 8'hAA}, {2'b00, 8'hAA}, {2'b00, 8'h55},
              {2'b00, 8'h0A}, {2'b01, 8'h03}, {2'b11, 8'h04}, {2'b10, 8'h00}, {2'b10, 8'h00}, {2'b01, 8'h00}};
        wo = 0;
        foreach (q[i]) begin
            cyc(q[i][9:8], q[i][7:0]);
            if (WINOPEN === 1'b1) wo++;
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL program i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
        total++;
        if (wo != 4) begin bad++; $display("FAIL program_winlen got=%0d exp=4", wo); end
        total++;
        if ({FWLEN, SWLEN, RSTLIM} !== 24'h0A0304) begin bad++; $display("FAIL program_regs got=%h exp=0a0304", {FWLEN, SWLEN, RSTLIM}); end
    endtask

    task automatic test_init();
        logic [9:0] q[$];
        int n_init, at;
        q = '{{2'b00, 8'hAA}, {2'b00, 8'h55}, {2'b10, 8'h08}, {2'b10, 8'h00}, {2'b10, 8'h00}, {2'b10, 8'h00}, {2'b01, 8'h00}};
        n_init = 0; at = -1;
        foreach (q[i]) begin
            cyc(q[i][9:8], q[i][7:0]);
            if (INIT === 1'b1) begin n_init++; at = i; end
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL init i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
        total++;
        if (n_init != 1 || at != 2) begin bad++; $display("FAIL init_pulse got=%0d@%0d exp=1@2", n_init, at); end
    endtask

    task automatic test_keyerr();
        logic [9:0] q[$];
        int n_err;
        logic [7:0] fw0;
        fw0 = FWLEN;
        q = '{{2'b00, 8'hAA}, {2'b00, 8'h12}, {2'b01, 8'h00}, {2'b00, 8'hAA}, {2'b01, 8'hAA}, {2'b01, 8'h00}};
        for (int i = 0; i <= KTMO; i++) q.push_back({2'b00, 8'hAA});
        q.push_back({2'b00, 8'h20});
        for (int i = 0; i < KTMO; i++) q.push_back({2'b00, 8'hAA});
        q.push_back({2'b00, 8'h55});
        for (int i = 0; i < 4; i++) q.push_back({2'b01, 8'h33});
        q.push_back({2'b01, 8'h00});
        n_err = 0;
        foreach (q[i]) begin
            cyc(q[i][9:8], q[i][7:0]);
            if (KEYERR === 1'b1) n_err++;
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL keyerr i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
        total++;
        if (n_err != 3) begin bad++; $display("FAIL keyerr_count got=%0d exp=3", n_err); end
        total++;
        if (FWLEN !== fw0 || SWLEN !== 8'h33) begin bad++; $display("FAIL keyerr_regs got=%h/%h exp=%h/33", FWLEN, SWLEN, fw0); end
    endtask

    task automatic test_cfgerr();
        logic [9:0] q[$];
        int n_err;
        logic [7:0] fw0;
        fw0 = FWLEN;
        q = '{{2'b00, 8'hAA}, {2'b00, 8'h55}, {2'b00, 8'h00}, {2'b01, 8'h00}, {2'b10, 8'h00}, {2'b11, 8'h00}, {2'b01, 8'h00}};
        n_err = 0;
        foreach (q[i]) begin
            cyc(q[i][9:8], q[i][7:0]);
            if (CFGERR === 1'b1) n_err++;
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL cfgerr i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
        total++;
        if (n_err != (LOCK_EN && m_lock ? 0 : 3) || FWLEN !== fw0) begin
            bad++; $display("FAIL cfgerr_count got=%0d fw=%h exp=3 fw=%h", n_err, FWLEN, fw0);
        end
    endtask

    task automatic test_reset_midwin();
        cyc(2'b00, 8'hAA);
        cyc(2'b00, 8'h55);
        cyc(2'b00, 8'h77);
        @(negedge CLK);
        ABUS = 2'b01; DBUS = 8'h44;
        #2 RST = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rst_midwin_async got=%h exp=%h", obs_vec(), exp_vec()); end
        @(posedge CLK);
        #1;
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rst_midwin_hold got=%h exp=%h", obs_vec(), exp_vec()); end
        @(negedge CLK);
        RST = 1'b1;
        cyc(2'b01, 8'h44);
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rst_midwin_after got=%h exp=%h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] q[$];
        q = '{{2'b00, 8'hAA}, {2'b00, 8'h55}, {2'b00, 8'hAA}, {2'b01, 8'h21}, {2'b00, 8'h55}, {2'b11, 8'h07},
              {2'b00, 8'hAA}, {2'b00, 8'h55}, {2'b01, 8'h09}, {2'b01, 8'h0B}, {2'b00, 8'hAA}, {2'b00, 8'hAA},
              {2'b01, 8'h00}};
        foreach (q[i]) begin
            cyc(q[i][9:8], q[i][7:0]);
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL back_to_back i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
    endtask

    task automatic test_lock();
        logic [9:0] q[$];
        int both;
        do_reset();
        q = '{{2'b00, 8'hAA}, {2'b00, 8'h55}, {2'b10, 8'h80}, {2'b01, 8'h00}, {2'b10, 8'h09}, {2'b11, 8'h02},
              {2'b01, 8'h00}, {2'b00, 8'hAA}, {2'b00, 8'h55}, {2'b00, 8'h20}, {2'b10, 8'h09}, {2'b00, 8'h00},
              {2'b01, 8'h11}, {2'b01, 8'h00}};
        both = 0;
        foreach (q[i]) begin
            cyc(q[i][9:8], q[i][7:0]);
            if (INIT === 1'b1 && SVC === 1'b1) both++;
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL lock i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
        total++;
        if (both != 2) begin bad++; $display("FAIL lock_init_svc got=%0d exp=2", both); end
        total++;
        if (FWLEN !== (LOCK_EN ? 8'hFF : 8'h20) || CFGLOCK !== LOCK_EN) begin
            bad++; $display("FAIL lock_state got=%h/%b exp=%h/%b", FWLEN, CFGLOCK, LOCK_EN ? 8'hFF : 8'h20, LOCK_EN);
        end
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        logic [7:0] d;
        int kind, n;
        do_reset();
        for (int s = 0; s < 60; s++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0) begin
                n = int'($urandom_range(1, 3));
                for (int i = 0; i < n; i++) q.push_back(10'($urandom_range(0, 1023)));
            end else begin
                n = int'($urandom_range(1, KTMO + 1));
                for (int i = 0; i < n; i++) q.push_back({2'b00, 8'hAA});
                if (kind == 3) q.push_back(10'($urandom_range(0, 1023)));
                else q.push_back({2'b00, 8'h55});
                for (int i = 0; i < 4; i++) begin
                    d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                    if (s < 45) d[7] = 1'b0;
                    q.push_back({2'($urandom_range(0, 3)), d});
                end
            end
        end
        foreach (q[i]) begin
            cyc(q[i][9:8], q[i][7:0]);
            total++;
            if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random i=%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
        end
    endtask

    initial begin
        RST = 1'b0;
        ABUS = 2'b00;
        DBUS = 8'h00;
        model_reset();
        test_reset();
        test_program();
        test_init();
        test_keyerr();
        test_cfgerr();
        test_reset_midwin();
        test_back_to_back();
        test_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
